// File: rtl/exe_pkg.sv
// exe_pkg: ALU command encodings, shifter types and FSM states for the execute stage
package exe_pkg;
  localparam logic [3:0] MOV = 4'b0001;
  localparam logic [3:0] MVN = 4'b1001;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] ADC = 4'b0011;
  localparam logic [3:0] SUB = 4'b0100;
  localparam logic [3:0] SBC = 4'b0101;
  localparam logic [3:0] AND = 4'b0110;
  localparam logic [3:0] ORR = 4'b0111;
  localparam logic [3:0] EOR = 4'b1000;
  localparam logic [3:0] MUL = 4'b1010;
  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
endpackage

// File: rtl/exe_mul_iter.sv
// exe_mul_iter: radix-2^MUL_STEP shift-add multiplier, low DATA_W bits of the product.
// MUL_EARLY_TERM_EN stops as soon as the remaining multiplier bits are zero.
module exe_mul_iter #(
  parameter int DATA_W = 32,
  parameter int MUL_STEP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int N = DATA_W / MUL_STEP;
  localparam int CW = $clog2(N + 1);
  logic [DATA_W-1:0] a_r, b_r;
  logic [CW-1:0] cnt;
  logic fin, last;
  // start retires the first digit, so done covers the step in flight this cycle
`ifdef MUL_EARLY_TERM_EN
  assign fin = (cnt == CW'(N)) || (b_r == '0);
  assign last = (cnt == CW'(N - 1)) || ((b_r >> MUL_STEP) == '0);
`else
  assign fin = cnt == CW'(N);
  assign last = cnt == CW'(N - 1);
`endif
  assign done = fin || last;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= CW'(N);
      a_r <= '0;
      b_r <= '0;
      product <= '0;
    end else if (abort) begin
      cnt <= CW'(N);
      a_r <= '0;
      b_r <= '0;
      product <= '0;
    end else if (start) begin
      cnt <= CW'(1);
      product <= a * DATA_W'(b[MUL_STEP-1:0]);
      a_r <= a << MUL_STEP;
      b_r <= b >> MUL_STEP;
    end else if (!fin) begin
      cnt <= cnt + 1'b1;
      product <= product + a_r * DATA_W'(b_r[MUL_STEP-1:0]);
      a_r <= a_r << MUL_STEP;
      b_r <= b_r >> MUL_STEP;
    end
endmodule

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: forwarding, Val2 shifter, ALU, branch target and iterative MUL with a valid/ready output register.
// Optional MUL_EARLY_TERM_EN shortens multiplies whose remaining multiplier bits are zero.
module exe_stage_mc import exe_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int IMM_W = 24,
  parameter int N_FWD = 2,
  parameter int MUL_STEP = 2,
  localparam int SW = $clog2(N_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              exe_cmd,
  input  logic                    mem_r_en,
  input  logic                    mem_w_en,
  input  logic                    imm,
  input  logic                    c_in,
  input  logic                    v_in,
  input  logic [DATA_W-1:0]       pc,
  input  logic [DATA_W-1:0]       val1,
  input  logic [DATA_W-1:0]       val_rm,
  input  logic [N_FWD*DATA_W-1:0] fwd_data,
  input  logic [SW-1:0]           sel_src1,
  input  logic [SW-1:0]           sel_src2,
  input  logic [11:0]             shift_operand,
  input  logic [IMM_W-1:0]        signed_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       alu_res,
  output logic [DATA_W-1:0]       branch_addr,
  output logic                    out_n,
  output logic                    out_z,
  output logic                    out_c,
  output logic                    out_v,
  output logic                    busy
);
  localparam int M = DATA_W - 1;
  state_t state, state_n;
  logic [DATA_W-1:0] src1, src2, val2, asr, b_eff, res, off, br, mul_prod, mul_br;
  logic [DATA_W:0] sum;
  logic [4:0] sh;
  logic load_ok, accept, is_mul, arith, sub, cin_add, c_res, v_res, mul_done, mul_c, mul_v;
  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input logic [4:0] r);
    return (x >> r) | (x << (DATA_W - int'(r)));
  endfunction
  always_comb begin
    src1 = sel_src1 == '0 ? val1 : '0;
    src2 = sel_src2 == '0 ? val_rm : '0;
    for (int k = 1; k <= N_FWD; k++) begin
      if (sel_src1 == SW'(k)) src1 = fwd_data[(k-1)*DATA_W +: DATA_W];
      if (sel_src2 == SW'(k)) src2 = fwd_data[(k-1)*DATA_W +: DATA_W];
    end
  end
  assign sh = shift_operand[11:7];
  assign asr = $signed(src2) >>> sh;
  assign val2 = (mem_r_en || mem_w_en) ? DATA_W'(shift_operand)
              : imm ? ror(DATA_W'(shift_operand[7:0]), {shift_operand[11:8], 1'b0})
              : shift_operand[6:5] == SH_LSL ? src2 << sh
              : shift_operand[6:5] == SH_LSR ? src2 >> sh
              : shift_operand[6:5] == SH_ASR ? asr
              : ror(src2, sh);
  // subtraction is a + ~b + carry, so C is the ARM no-borrow flag
  assign arith = exe_cmd == ADD || exe_cmd == ADC || exe_cmd == SUB || exe_cmd == SBC;
  assign sub = exe_cmd == SUB || exe_cmd == SBC;
  assign b_eff = sub ? ~val2 : val2;
  assign cin_add = exe_cmd == SUB ? 1'b1 : (exe_cmd == ADC || exe_cmd == SBC) ? c_in : 1'b0;
  assign sum = {1'b0, src1} + {1'b0, b_eff} + (DATA_W + 1)'(cin_add);
  assign c_res = arith ? sum[DATA_W] : c_in;
  assign v_res = arith ? (src1[M] == b_eff[M]) && (sum[M] != src1[M]) : v_in;
  always_comb begin
    case (exe_cmd)
      MOV: res = val2;
      MVN: res = ~val2;
      ADD, ADC, SUB, SBC: res = sum[M:0];
      AND: res = src1 & val2;
      ORR: res = src1 | val2;
      EOR: res = src1 ^ val2;
      default: res = '0;
    endcase
  end
  assign off = DATA_W'($signed(signed_imm));
  assign br = pc + (off << 2);
  assign load_ok = !out_valid || out_ready;
  assign in_ready = state == S_IDLE && load_ok;
  assign accept = in_valid && in_ready && !flush;
  assign is_mul = exe_cmd == MUL;
  assign busy = state != S_IDLE;
  exe_mul_iter #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) u_mul (
    .clk(clk), .rst(rst), .start(accept && is_mul), .abort(flush),
    .a(src1), .b(src2), .done(mul_done), .product(mul_prod)
  );
  always_comb
    state_n = flush ? S_IDLE
            : (accept && is_mul) ? S_MUL
            : (state == S_MUL && mul_done) ? S_DONE
            : (state == S_DONE && load_ok) ? S_IDLE
            : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      alu_res <= '0;
      branch_addr <= '0;
      {out_n, out_z, out_c, out_v} <= '0;
      mul_br <= '0;
      mul_c <= 1'b0;
      mul_v <= 1'b0;
    end else begin
      if (accept && is_mul) begin
        mul_br <= br;
        mul_c <= c_in;
        mul_v <= v_in;
      end
      if (flush) out_valid <= 1'b0;
      else if (accept && !is_mul) begin
        out_valid <= 1'b1;
        alu_res <= res;
        branch_addr <= br;
        {out_n, out_z, out_c, out_v} <= {res[M], res == '0, c_res, v_res};
      end else if (state == S_DONE && load_ok) begin
        out_valid <= 1'b1;
        alu_res <= mul_prod;
        branch_addr <= mul_br;
        {out_n, out_z, out_c, out_v} <= {mul_prod[M], mul_prod == '0, mul_c, mul_v};
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
Parametrised, multi-cycle execute stage for the ARM pipeline. It performs operand forwarding from N_FWD sources, Val2 generation (immediate rotate, register shift, memory offset), the ALU, branch-target computation, and an iterative MUL.
Results go into an internal output register with a valid/ready handshake toward MEM, and a stall goes back to ID while a multiply is in progress.

Parameters:
DATA_W, 32, datapath width (even, >= 16)
IMM_W, 24, branch signed-immediate width
N_FWD, 2, number of forwarding sources
MUL_STEP, 2, multiplier bits retired per cycle (divides DATA_W)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  discard accepted/in-flight op
in_valid  in  1  ID presents an op
in_ready  out  1  stage can accept this cycle
exe_cmd  in  4  ALU command (package encoding)
mem_r_en  in  1  load
mem_w_en  in  1  store
imm  in  1  immediate operand form
c_in  in  1  current C flag
v_in  in  1  current V flag
pc  in  DATA_W  PC of the op (already +4)
val1  in  DATA_W  Rn value
val_rm  in  DATA_W  Rm value
fwd_data  in  N_FWD*DATA_W  forwarded values; source k occupies slice k
sel_src1  in  $clog2(N_FWD+1)  0=val1, k=fwd source k-1
sel_src2  in  $clog2(N_FWD+1)  0=val_rm, k=fwd source k-1
shift_operand  in  12  ARM shifter operand
signed_imm  in  IMM_W  branch offset
out_valid  out  1  result register holds a valid op
out_ready  in  1  MEM accepts
alu_res  out  DATA_W  result
branch_addr  out  DATA_W  pc + (sext(signed_imm) << 2), modulo 2^DATA_W
out_n, out_z, out_c, out_v  out  1 each  flags
busy  out  1  multiply in progress

Behaviour:
- Reset: out_valid=0, alu_res=0, branch_addr=0, flags=0, busy=0, FSM=IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept occurs when in_valid && in_ready. Forwarding muxes are sampled only at accept; a sel value > N_FWD selects 0.
- Val2 rules:
  - mem_r_en|mem_w_en: zero-extend shift_operand[11:0].
  - imm=1: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - Otherwise: Rm shifted by shift_operand[6:5] (LSL, LSR, ASR, ROR), amount shift_operand[11:7].
- Single-cycle commands: the result and flags are registered on the accept edge; out_valid=1 the next cycle. Latency is 1.
- Flag rules:
  - N = res[MSB]; Z = (res==0).
  - C, V come from arithmetic ops. For SUB/SBC, C=1 means no borrow.
  - Logic ops and MOV/MVN: C=c_in, V=v_in.
- MUL (exe_cmd==MUL):
  - IDLE -> MUL on accept. busy=1 and in_ready=0.
  - Runs DATA_W/MUL_STEP cycles of shift-add, then -> DONE. DONE writes the low DATA_W bits of the product, returns to IDLE, and asserts out_valid.
  - Flags: N, Z from the result; C=c_in; V=v_in.
- Backpressure: while out_valid && !out_ready, all outputs are held stable.
- A multiply result waits in DONE until the output register is free.
- flush (takes priority over accept): out_valid→0, FSM→IDLE, busy→0, partial product discarded. in_ready is 1 the cycle after a flush.
- Reset mid-multiply: same as reset.
- Simultaneous out_ready and accept: the old result is consumed and the new one loaded on the same edge.

Optional Feature:
MUL_EARLY_TERM_EN
- Defined: MUL moves to DONE as soon as the remaining multiplier bits are zero, for a minimum of 1 iteration.
- Undefined: fixed DATA_W/MUL_STEP iterations.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package exe_pkg contains:
  - ALU command localparams: MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000, MUL=1010.
  - Shift-type constants.
  - FSM state enum: IDLE, MUL, DONE.
- One sub-module, exe_mul_iter: start/operands in, done/product out, with an abort input.

Test Plan:
1. ADD, val1=5, val_rm=3, shift_operand LSL #2 -> alu_res=17, NZCV=0000, out_valid 1 cycle after accept.
2. SUB, val1=0, Val2=1 -> alu_res=0xFFFFFFFF, N=1, Z=0, C=0, V=0.
3. sel_src1=2, fwd_data slice 1=0x1234, ORR with imm 0 -> alu_res=0x1234; sel_src1=3 selects 0.
4. MUL 0x10000*0x10000 -> alu_res=0, Z=1, in_ready low 16 cycles (DATA_W=32, MUL_STEP=2); with the macro, 3*2 completes in 1 iteration.
5. out_ready held low 3 cycles after an ADD result -> outputs stable, in_ready=0, next op accepted on the release edge.
6. flush in MUL iteration 5 -> no out_valid, busy=0 and in_ready=1 next cycle; a following ADD completes normally.
